// File: rtl/custom_buff_use_sequencer.sv
// rtl/custom_buff_use_sequencer.sv - step sequencer driving the buffer-usage schedule
//
// Walks a fixed step schedule (cnt 0..LAST_CNT) after a start request and
// presents the per-step enable vector for the four operand buffers. It also
// keeps one read pointer per buffer, and each pointer advances on every edge
// where its buffer is enabled.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   start      - run request, sampled in IDLE only
//   stall      - freezes cnt and pointers, masks buff_use
//   abort      - synchronous cancel while running, no done pulse
//   busy       - high while running
//   done       - one-cycle pulse after the last step
//   cnt        - current step index (registered)
//   buff_use   - buffer enables for the current step, bit3 = buffer 3
//   rd_addr0-3 - per-buffer read pointers (registered)

module custom_buff_use_sequencer #(
  parameter int unsigned LAST_CNT = 25,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [4:0]        cnt,
  output logic [3:0]        buff_use,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  output logic [ADDR_W-1:0] rd_addr2,
  output logic [ADDR_W-1:0] rd_addr3
);

  localparam logic [4:0]        LAST  = 5'(LAST_CNT);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] rd_addr [4];

  function automatic logic [3:0] sched_lookup(input logic [4:0] c);
    logic [3:0] v;
    v = 4'b0000;
    case (c)
      5'd5:  v = 4'b1000;
      5'd6:  v = 4'b1100;
      5'd7:  v = 4'b0110;
      5'd8:  v = 4'b0010;
      5'd9:  v = 4'b1001;
      5'd10: v = 4'b1101;
      5'd11: v = 4'b1000;
      5'd12: v = 4'b1110;
      5'd13: v = 4'b0100;
      5'd14: v = 4'b0110;
      5'd15: v = 4'b0000;
      5'd16: v = 4'b0011;
      5'd17: v = 4'b1011;
      5'd18: v = 4'b0001;
      5'd19: v = 4'b1101;
      5'd20: v = 4'b1000;
      5'd21: v = 4'b1100;
      5'd22: v = 4'b0010;
      5'd23: v = 4'b0011;
      5'd24: v = 4'b1001;
      5'd25: v = 4'b1000;
      default: v = 4'b0000;
    endcase
    return v;
  endfunction

  // Combinational on purpose: stall must blank the enables in the same cycle.
  assign buff_use = (state == RUN && !stall) ? sched_lookup(cnt) : 4'b0000;

  assign rd_addr0 = rd_addr[0];
  assign rd_addr1 = rd_addr[1];
  assign rd_addr2 = rd_addr[2];
  assign rd_addr3 = rd_addr[3];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 5'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      for (int i = 0; i < 4; i++) rd_addr[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= 5'd0;
            for (int i = 0; i < 4; i++) rd_addr[i] <= '0;
          end
        end
        RUN: begin
          // A pointer advances whenever its enable is presented, including
          // the final step and an aborting cycle; wrap is silent.
          for (int i = 0; i < 4; i++) begin
            if (buff_use[i]) rd_addr[i] <= rd_addr[i] + ONE_A;
          end
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= 5'd0;
          end else if (!stall) begin
            if (cnt == LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_custom_buff_use_sequencer.sv
// tb/tb_custom_buff_use_sequencer.sv - self-checking bench for custom_buff_use_sequencer

module tb_custom_buff_use_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       abort;
  logic       busy;
  logic       done;
  logic [4:0] cnt;
  logic [3:0] buff_use;
  logic [3:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;

  int checks   = 0;
  int failures = 0;

  custom_buff_use_sequencer #(.LAST_CNT(25), .ADDR_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stall    (stall),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .cnt      (cnt),
    .buff_use (buff_use),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_addr3 (rd_addr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 running, 2 done-cycle.
  int sched [32] = '{0, 0, 0, 0, 0, 8, 12, 6, 2, 9, 13, 8, 14, 4, 6, 0,
                     3, 11, 1, 13, 8, 12, 2, 3, 9, 8, 0, 0, 0, 0, 0, 0};
  int m_phase;
  int m_cnt;
  int m_ptr [4];

  task automatic m_reset();
    m_phase = 0;
    m_cnt   = 0;
    for (int i = 0; i < 4; i++) m_ptr[i] = 0;
  endtask

  function automatic int m_use();
    return (m_phase == 1 && !stall) ? sched[m_cnt] : 0;
  endfunction

  function automatic logic [26:0] exp_vec();
    return {(m_phase == 1), (m_phase == 2), 5'(m_cnt), 4'(m_use()),
            4'(m_ptr[3]), 4'(m_ptr[2]), 4'(m_ptr[1]), 4'(m_ptr[0])};
  endfunction

  function automatic logic [26:0] obs();
    return {busy, done, cnt, buff_use, rd_addr3, rd_addr2, rd_addr1, rd_addr0};
  endfunction

  // Wait for the active edge, then apply the schedule rules to the model.
  task automatic m_edge();
    int u;
    @(posedge clk);
    if (!rst_n) begin
      m_reset();
    end else begin
      u = m_use();
      for (int i = 0; i < 4; i++)
        if ((u >> i) & 1) m_ptr[i] = (m_ptr[i] + 1) % 16;
      case (m_phase)
        0: if (start) begin
             m_phase = 1;
             m_cnt   = 0;
             for (int i = 0; i < 4; i++) m_ptr[i] = 0;
           end
        1: if (abort) begin
             m_phase = 0;
             m_cnt   = 0;
           end else if (!stall) begin
             if (m_cnt == 25) m_phase = 2;
             else m_cnt = m_cnt + 1;
           end
        default: m_phase = 0;
      endcase
    end
  endtask

  task automatic cyc(input logic s, input logic st, input logic ab);
    @(negedge clk);
    start = s;
    stall = st;
    abort = ab;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0; stall = 1'b0; abort = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 27'd0) begin
      failures++;
      $display("FAIL reset_hold got=%h exp=0", obs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== 27'd0) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h exp=0", k, obs());
      end
      m_edge();
    end
  endtask

  task automatic test_full_run();
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    for (int k = 0; k < 30; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL full_run_model cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      if (k <= 25) begin
        checks++;
        if (cnt !== 5'(k)) begin
          failures++;
          $display("FAIL full_run_cnt cyc=%0d got=%0d exp=%0d", k, cnt, k);
        end
      end
      checks++;
      if (done !== (k == 26)) begin
        failures++;
        $display("FAIL full_run_done cyc=%0d got=%0b exp=%0b", k, done, (k == 26));
      end
      m_edge();
    end
    checks++;
    if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== {4'd12, 4'd8, 4'd8, 4'd8}) begin
      failures++;
      $display("FAIL full_run_ptrs got=%0d/%0d/%0d/%0d exp=12/8/8/8",
               rd_addr3, rd_addr2, rd_addr1, rd_addr0);
    end
  endtask

  task automatic test_stall();
    int first_done;
    logic st;
    first_done = -1;
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    for (int k = 0; k < 34; k++) begin
      st = (k >= 10 && k < 13);
      cyc(1'b0, st, 1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL stall_model cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      if (st) begin
        checks++;
        if (cnt !== 5'd10 || buff_use !== 4'b0000) begin
          failures++;
          $display("FAIL stall_hold cyc=%0d got cnt=%0d use=%b exp cnt=10 use=0000", k, cnt, buff_use);
        end
      end
      if (done === 1'b1 && first_done < 0) first_done = k;
      m_edge();
    end
    checks++;
    if (first_done != 29) begin
      failures++;
      $display("FAIL stall_done_cycle got=%0d exp=29", first_done);
    end
    checks++;
    if ({rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== {4'd12, 4'd8, 4'd8, 4'd8}) begin
      failures++;
      $display("FAIL stall_ptrs got=%0d/%0d/%0d/%0d exp=12/8/8/8",
               rd_addr3, rd_addr2, rd_addr1, rd_addr0);
    end
  endtask

  task automatic test_abort();
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    for (int k = 0; k <= 17; k++) begin
      cyc(1'b0, 1'b0, (k == 17));
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL abort_model cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      m_edge();
    end
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || cnt !== 5'd0) begin
        failures++;
        $display("FAIL abort_idle cyc=%0d got busy=%0b done=%0b cnt=%0d exp 0/0/0", k, busy, done, cnt);
      end
      m_edge();
    end
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (busy !== 1'b1 || cnt !== 5'd0 || {rd_addr3, rd_addr2, rd_addr1, rd_addr0} !== 16'd0) begin
      failures++;
      $display("FAIL abort_restart got busy=%0b cnt=%0d ptrs=%h exp busy=1 cnt=0 ptrs=0000",
               busy, cnt, {rd_addr3, rd_addr2, rd_addr1, rd_addr0});
    end
    m_edge();
    for (int k = 1; k < 30; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL abort_rerun cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      m_edge();
    end
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    for (int k = 0; k < 12; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      m_edge();
    end
    cyc(1'b0, 1'b0, 1'b0);
    checks++;
    if (cnt !== 5'd12 || busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got cnt=%0d busy=%0b exp cnt=12 busy=1", cnt, busy);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs() !== 27'd0) begin
      failures++;
      $display("FAIL areset_immediate got=%h exp=0", obs());
    end
    m_edge();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL areset_after cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      m_edge();
    end
  endtask

  task automatic test_start_held();
    cyc(1'b1, 1'b0, 1'b0);
    m_edge();
    for (int k = 0; k < 34; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL held_model cyc=%0d got=%h exp=%h", k, obs(), exp_vec());
      end
      if (k == 26 || k == 27 || k == 28) begin
        checks++;
        if ({busy, done} !== ((k == 26) ? 2'b01 : (k == 27) ? 2'b00 : 2'b10) ||
            (k == 28 && cnt !== 5'd0)) begin
          failures++;
          $display("FAIL held_edge cyc=%0d got busy=%0b done=%0b cnt=%0d", k, busy, done, cnt);
        end
      end
      m_edge();
    end
    cyc(1'b0, 1'b0, 1'b1);
    m_edge();
    cyc(1'b0, 1'b0, 1'b0);
    m_edge();
  endtask

  task automatic test_random();
    logic s, st, ab;
    for (int k = 0; k < 600; k++) begin
      s  = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      cyc(s, st, ab);
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc=%0d in=%b%b%b got=%h exp=%h", k, s, st, ab, obs(), exp_vec());
      end
      m_edge();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_run();
    test_stall();
    test_abort();
    test_async_reset();
    test_start_held();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/custom_buff_use_sequencer.md
Name: custom_buff_use_sequencer

Overview:
Step sequencer that drives the buffer-usage schedule for the custom datapath. It generates the 5-bit step count and the 4-bit buffer-enable vector (buff_use), with a start/done handshake and stall support. It also keeps one read pointer per buffer, advanced on every cycle that buffer is enabled. It sits between the top-level controller and the four operand buffers.

Parameters:
- LAST_CNT, 25: final step index of a run; legal range 0..31.
- ADDR_W, 4: width of each per-buffer read pointer.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled in IDLE only.
- stall  in  1  freezes the step count and pointers; masks buff_use.
- abort  in  1  synchronous cancel; returns to IDLE with no done.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse after the last step completes.
- cnt  out  5  current step index (registered).
- buff_use  out  4  buffer enables for the current step; bit3 = buffer 3.
- rd_addr0..rd_addr3  out  ADDR_W each  per-buffer read pointers (registered).

Behaviour:
- Reset: async on rst_n=0.
  - Affects: state=IDLE, cnt=0, all rd_addr=0, done=0, busy=0, buff_use=0.
  - Applies at any time, including mid-run; the run is lost with no done pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge -> RUN at that edge, cnt=0, all rd_addr cleared to 0.
  - start=0 -> stay in IDLE.
- RUN:
  - busy=1.
  - abort=1 -> IDLE at the next edge, cnt=0, no done. abort has priority over stall and advance.
  - stall=1 -> cnt and rd_addr hold; buff_use=0000.
  - stall=0 and cnt!=LAST_CNT -> cnt increments by 1.
  - stall=0 and cnt==LAST_CNT -> DONE at the next edge; cnt then holds its value.
  - start is ignored while in RUN.
- DONE:
  - Lasts exactly one cycle, with done=1 and busy=0.
  - Always returns to IDLE; start seen during DONE is ignored.
- buff_use:
  - Combinational lookup of the registered cnt.
  - Driven only when state==RUN and stall==0; otherwise 0000.
- Schedule table, cnt -> buff_use:
  - 0-4 -> 0000
  - 5 -> 1000, 6 -> 1100, 7 -> 0110, 8 -> 0010
  - 9 -> 1001, 10 -> 1101, 11 -> 1000, 12 -> 1110
  - 13 -> 0100, 14 -> 0110, 15 -> 0000, 16 -> 0011
  - 17 -> 1011, 18 -> 0001, 19 -> 1101, 20 -> 1000
  - 21 -> 1100, 22 -> 0010, 23 -> 0011, 24 -> 1001, 25 -> 1000
  - 26-31 -> 0000
- Read pointers:
  - At each edge where buff_use[i]=1, rd_addr_i <= rd_addr_i + 1, modulo 2^ADDR_W (wrap silently).
  - rd_addr_i presented during a cycle is the address consumed in that cycle.
- Latency:
  - Without stall, start is accepted at edge E and cnt=k is valid in cycle E+k.
  - done is high in cycle E+LAST_CNT+1; busy is high for LAST_CNT+1 cycles.
  - Each stalled cycle adds one cycle to this latency.
- Simultaneous events:
  - abort and stall together -> abort wins.
  - abort and start while in IDLE -> start is taken; abort acts only in RUN.
  - A stall held through cnt==LAST_CNT delays DONE until the first unstalled cycle.

Test Plan:
- Reset then idle: rst_n low, release, start=0 for 10 cycles -> all outputs stay 0.
- Full run, no stall, start pulsed at edge E:
  - cnt ramps 0..25 in cycles E..E+25, and buff_use matches the table each cycle.
  - done=1 only in cycle E+26.
  - Final pointers: rd_addr3=12, rd_addr2=8, rd_addr1=8, rd_addr0=8.
- Stall at cnt=10 for 3 cycles:
  - cnt holds at 10, buff_use=0000, and pointers hold during the stall.
  - done shifts to E+29; final pointers unchanged (12/8/8/8).
- Abort at cnt=17 -> IDLE next cycle, no done pulse. A following start restarts from cnt=0 with pointers cleared.
- rst_n asserted at cnt=12 -> all outputs 0 immediately, without waiting for a clock edge.
- start held high through the run and the DONE cycle -> start is ignored in RUN and DONE. A new run begins at the first IDLE edge where start=1.
